// File: rtl/best_arr_sender_pkg.sv
// Shared accelerator constants, FSM/phase encodings and a counter-width helper
// for the best-array sender.
package best_arr_sender_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int ROW_SIZE   = 26;
  localparam int COL_SIZE   = 19;
  localparam int BLOCKING   = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LATCH,
    PUSH_IDX,
    PUSH_HI,
    PUSH_LO,
    DONE
  } state_t;

  typedef enum logic {
    IDX,
    DIST
  } phase_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/best_arr_sender_addr_gen.sv
// Scan-order generator: walks px/x/y/xi, hops over out-of-row columns without
// emitting them, and flags the final tuple of a pass.
module best_arr_addr_gen #(
  parameter int ROW_SIZE   = best_arr_sender_pkg::ROW_SIZE,
  parameter int COL_SIZE   = best_arr_sender_pkg::COL_SIZE,
  parameter int BLOCKING   = best_arr_sender_pkg::BLOCKING,
  parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
  input  logic                  io_clk,
  input  logic                  io_rst_n,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  import best_arr_sender_pkg::*;

  localparam int HALF  = ROW_SIZE / 2;
  localparam int X_CNT = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int XW    = cnt_width(X_CNT);
  localparam int YW    = cnt_width(COL_SIZE);
  localparam int XIW   = cnt_width(BLOCKING);

  logic                  px;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [XIW-1:0]        xi;
  logic [ADDR_WIDTH-1:0] col;
  logic                  xi_wrap;
  logic                  y_wrap;
  logic                  x_wrap;

  // The last block column is partial: wrapping xi at the half-row edge is what
  // skips the unused tuples without spending a read on them.
  assign col     = ADDR_WIDTH'(x) * ADDR_WIDTH'(BLOCKING) + ADDR_WIDTH'(xi);
  assign xi_wrap = (xi == XIW'(BLOCKING - 1)) || (col == ADDR_WIDTH'(HALF - 1));
  assign y_wrap  = (y == YW'(COL_SIZE - 1));
  assign x_wrap  = (x == XW'(X_CNT - 1));
  assign last    = px && x_wrap && y_wrap && xi_wrap;
  assign addr    = (px ? ADDR_WIDTH'(HALF) : '0)
                 + ADDR_WIDTH'(y) * ADDR_WIDTH'(ROW_SIZE) + col;

  always_ff @(posedge io_clk) begin
    if (!io_rst_n || clear) begin
      px <= 1'b0;
      x  <= '0;
      y  <= '0;
      xi <= '0;
    end else if (advance) begin
      if (!xi_wrap) begin
        xi <= xi + XIW'(1);
      end else begin
        xi <= '0;
        if (!y_wrap) begin
          y <= y + YW'(1);
        end else begin
          y <= '0;
          if (!x_wrap) begin
            x <= x + XW'(1);
          end else begin
            x  <= '0;
            px <= ~px;
          end
        end
      end
    end
  end

endmodule

// File: rtl/best_arr_sender.sv
// Streams the best-match array to the output FIFO: one pass of indices, then a
// pass of distances split high/low. States: IDLE, RD, LATCH, PUSH_IDX/HI/LO, DONE.
module best_arr_sender #(
  parameter int DATA_WIDTH = best_arr_sender_pkg::DATA_WIDTH,
  parameter int ROW_SIZE   = best_arr_sender_pkg::ROW_SIZE,
  parameter int COL_SIZE   = best_arr_sender_pkg::COL_SIZE,
  parameter int BLOCKING   = best_arr_sender_pkg::BLOCKING,
  parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
  input  logic                    io_clk,
  input  logic                    io_rst_n,
  input  logic                    send_best_arr,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_idx,
  input  logic [2*DATA_WIDTH-1:0] rd_dist,
  output logic                    out_fifo_wenq,
  output logic [DATA_WIDTH-1:0]   out_fifo_wdata,
  input  logic                    out_fifo_wfull_n,
  output logic                    busy,
  output logic                    send_done
);
  import best_arr_sender_pkg::*;

  state_t                  state, state_nxt;
  phase_t                  phase, phase_nxt;
  logic [DATA_WIDTH-1:0]   idx_q;
  logic [2*DATA_WIDTH-1:0] dist_q;
  logic                    gen_clear;
  logic                    gen_advance;
  logic                    gen_last;

  best_arr_addr_gen #(
    .ROW_SIZE  (ROW_SIZE),
    .COL_SIZE  (COL_SIZE),
    .BLOCKING  (BLOCKING),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .io_clk  (io_clk),
    .io_rst_n(io_rst_n),
    .clear   (gen_clear),
    .advance (gen_advance),
    .addr    (rd_addr),
    .last    (gen_last)
  );

  always_ff @(posedge io_clk) begin
    if (!io_rst_n) begin
      state  <= IDLE;
      phase  <= IDX;
      idx_q  <= '0;
      dist_q <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (state == LATCH) begin
        idx_q  <= rd_idx;
        dist_q <= rd_dist;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    gen_clear      = 1'b0;
    gen_advance    = 1'b0;
    rd_en          = 1'b0;
    out_fifo_wenq  = 1'b0;
    out_fifo_wdata = '0;
    busy           = (state != IDLE);
    send_done      = 1'b0;
    case (state)
      IDLE: begin
        if (send_best_arr) begin
          phase_nxt = IDX;
          gen_clear = 1'b1;
          state_nxt = RD;
        end
      end
      RD: begin
        rd_en     = 1'b1;
        state_nxt = LATCH;
      end
      LATCH: state_nxt = (phase == IDX) ? PUSH_IDX : PUSH_HI;
      PUSH_IDX: begin
        out_fifo_wenq  = out_fifo_wfull_n;
        out_fifo_wdata = idx_q;
        if (out_fifo_wfull_n) begin
          state_nxt = RD;
          if (gen_last) begin
            phase_nxt = DIST;
            gen_clear = 1'b1;
          end else begin
            gen_advance = 1'b1;
          end
        end
      end
      PUSH_HI: begin
        out_fifo_wenq  = out_fifo_wfull_n;
        out_fifo_wdata = dist_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (out_fifo_wfull_n) state_nxt = PUSH_LO;
      end
      PUSH_LO: begin
        out_fifo_wenq  = out_fifo_wfull_n;
        out_fifo_wdata = dist_q[DATA_WIDTH-1:0];
        if (out_fifo_wfull_n) begin
          if (gen_last) begin
            state_nxt = DONE;
          end else begin
            gen_advance = 1'b1;
            state_nxt   = RD;
          end
        end
      end
      DONE: begin
        send_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_best_arr_sender.sv
// Self-checking bench: a loop-level model of the scan order predicts every read
// address and pushed word; literal expectations pin that model.
module tb_best_arr_sender;
  localparam int DW = 11;
  localparam int AW = 9;
  localparam int N  = 494;
  localparam int TIMEOUT = 20000;

  logic          io_clk = 1'b0;
  logic          io_rst_n;
  logic          send_best_arr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_idx = '0;
  logic [2*DW-1:0] rd_dist = '0;
  logic          out_fifo_wenq;
  logic [DW-1:0] out_fifo_wdata;
  logic          out_fifo_wfull_n = 1'b1;
  logic          busy;
  logic          send_done;

  best_arr_sender dut (
    .io_clk          (io_clk),
    .io_rst_n        (io_rst_n),
    .send_best_arr   (send_best_arr),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_idx          (rd_idx),
    .rd_dist         (rd_dist),
    .out_fifo_wenq   (out_fifo_wenq),
    .out_fifo_wdata  (out_fifo_wdata),
    .out_fifo_wfull_n(out_fifo_wfull_n),
    .busy            (busy),
    .send_done       (send_done)
  );

  always #5 io_clk = ~io_clk;

  logic [DW-1:0]   mem_idx  [0:N-1];
  logic [2*DW-1:0] mem_dist [0:N-1];

  always @(posedge io_clk) begin
    if (rd_en) begin
      rd_idx  <= mem_idx[rd_addr];
      rd_dist <= mem_dist[rd_addr];
    end
  end

  bit bp_en = 1'b0;
  always @(posedge io_clk) begin
    #1;
    if (bp_en) out_fifo_wfull_n = 1'($urandom_range(0, 1));
    else       out_fifo_wfull_n = 1'b1;
  end

  int n_pass = 0;
  int n_total = 0;
  int exp_words[$];
  int exp_addrs[$];
  int got_words[$];
  int got_addrs[$];
  int push_cnt, rd_cnt, done_cnt;
  int neg_cyc = 0;
  int start_neg, first_rd_neg, first_wenq_neg;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail(input string name, input longint act);
    n_total++;
    $display("FAIL %s: got %0d expected none", name, act);
  endtask

  // Scan order written directly as the nested loop over the image geometry.
  task automatic build_model();
    exp_words.delete();
    exp_addrs.delete();
    for (int ph = 0; ph < 2; ph++)
      for (int px = 0; px < 2; px++)
        for (int x = 0; x < 4; x++)
          for (int y = 0; y < 19; y++)
            for (int xi = 0; xi < 4; xi++) begin
              int col, a;
              col = x * 4 + xi;
              if (col >= 13) continue;
              a = px * 13 + y * 26 + col;
              exp_addrs.push_back(a);
              if (ph == 0) begin
                exp_words.push_back(int'(mem_idx[a]));
              end else begin
                exp_words.push_back(int'(mem_dist[a]) / 2048);
                exp_words.push_back(int'(mem_dist[a]) % 2048);
              end
            end
  endtask

  task automatic clear_run();
    got_words.delete();
    got_addrs.delete();
    push_cnt = 0;
    rd_cnt = 0;
    done_cnt = 0;
    start_neg = -1;
    first_rd_neg = -1;
    first_wenq_neg = -1;
  endtask

  always @(negedge io_clk) begin
    neg_cyc++;
    if (out_fifo_wenq) begin
      if (first_wenq_neg < 0) first_wenq_neg = neg_cyc;
      chk("wenq_while_full", out_fifo_wfull_n, 1);
      if (push_cnt < exp_words.size()) chk("word", out_fifo_wdata, exp_words[push_cnt]);
      else fail("unexpected_push", out_fifo_wdata);
      got_words.push_back(int'(out_fifo_wdata));
      push_cnt++;
    end
    if (rd_en) begin
      if (first_rd_neg < 0) first_rd_neg = neg_cyc;
      if (rd_cnt < exp_addrs.size()) chk("rd_addr", rd_addr, exp_addrs[rd_cnt]);
      else fail("unexpected_read", rd_addr);
      got_addrs.push_back(int'(rd_addr));
      rd_cnt++;
    end
    if (send_done) done_cnt++;
  end

  task automatic pulse_start(input bit record);
    @(posedge io_clk) #1 send_best_arr = 1'b1;
    @(posedge io_clk) #1 send_best_arr = 1'b0;
    if (record) start_neg = neg_cyc;
  endtask

  task automatic wait_pushes(input int n);
    int t = 0;
    while (push_cnt < n && t < TIMEOUT) begin
      @(posedge io_clk);
      t++;
    end
    if (t >= TIMEOUT) fail("timeout_pushes", push_cnt);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wenq"}, out_fifo_wenq, 0);
    chk({tag, "_wdata"}, out_fifo_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_send_done"}, send_done, 0);
  endtask

  task automatic run_transfer(input bit bp, input int busy_at, input bit done_poke);
    int t = 0;
    build_model();
    clear_run();
    bp_en = bp;
    pulse_start(1'b1);
    if (busy_at >= 0) begin
      wait_pushes(busy_at);
      pulse_start(1'b0);
    end
    if (done_poke) begin
      wait_pushes(3 * N);
      #1 send_best_arr = 1'b1;
      @(posedge io_clk) #1 send_best_arr = 1'b0;
    end
    while (done_cnt == 0 && t < TIMEOUT) begin
      @(posedge io_clk);
      t++;
    end
    if (t >= TIMEOUT) fail("timeout_done", push_cnt);
    repeat (12) @(posedge io_clk);
    bp_en = 1'b0;
    chk("push_total", push_cnt, 3 * N);
    chk("read_total", rd_cnt, 2 * N);
    chk("send_done_count", done_cnt, 1);
    chk("rd_en_latency", first_rd_neg, start_neg + 1);
    chk("first_wenq_not_early", (first_wenq_neg >= start_neg + 3) ? 1 : 0, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    io_rst_n = 1'b0;
    send_best_arr = 1'b0;
    for (int a = 0; a < N; a++) begin
      mem_idx[a]  = DW'(a);
      mem_dist[a] = (2 * DW)'(a * 3 + 2048);
    end
    clear_run();
    repeat (3) @(posedge io_clk);
    #1 check_idle_outputs("reset");
    io_rst_n = 1'b1;
    repeat (2) @(posedge io_clk);

    // Seeded memory, no backpressure.
    run_transfer(1'b0, -1, 1'b0);
    if (got_words.size() >= 5) begin
      chk("first_word0", got_words[0], 0);
      chk("first_word1", got_words[1], 1);
      chk("first_word2", got_words[2], 2);
      chk("first_word3", got_words[3], 3);
      chk("first_word4", got_words[4], 26);
    end else fail("short_run_a", got_words.size());
    if (got_words.size() >= 230 && got_addrs.size() >= 230) begin
      chk("push229_word", got_words[228], 12);
      chk("push229_addr", got_addrs[228], 12);
      chk("after_skip_addr", got_addrs[229], 38);
    end else fail("short_run_a_skip", got_words.size());
    chk("dist_first_hi_seed", (got_words.size() > 494) ? got_words[494] : -1, 1);
    chk("dist_first_lo_seed", (got_words.size() > 495) ? got_words[495] : -1, 0);

    // Distance split under random backpressure.
    mem_dist[0] = 22'h2ABCD;
    run_transfer(1'b1, -1, 1'b0);
    chk("dist_hi_2ABCD", (got_words.size() > 494) ? got_words[494] : -1, 'h055);
    chk("dist_lo_2ABCD", (got_words.size() > 495) ? got_words[495] : -1, 'h3CD);
    mem_dist[0] = 22'd2048;

    // Reset in the middle of a transfer.
    build_model();
    clear_run();
    pulse_start(1'b1);
    wait_pushes(300);
    @(posedge io_clk) #1 io_rst_n = 1'b0;
    @(posedge io_clk) #1;
    exp_words.delete();
    exp_addrs.delete();
    push_cnt = 0;
    rd_cnt = 0;
    #3 check_idle_outputs("mid_reset");
    @(posedge io_clk) #1 io_rst_n = 1'b1;
    repeat (20) @(posedge io_clk);
    chk("no_push_after_reset", push_cnt, 0);
    run_transfer(1'b0, -1, 1'b0);
    chk("restart_addr0", (got_addrs.size() > 0) ? got_addrs[0] : -1, 0);

    // Start while busy and during DONE must be ignored.
    run_transfer(1'b0, 100, 1'b1);

    // Random memory contents with backpressure.
    for (int a = 0; a < N; a++) begin
      mem_idx[a]  = DW'($urandom);
      mem_dist[a] = (2 * DW)'($urandom);
    end
    run_transfer(1'b1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
